// File: rtl/led_arb_pkg.sv
// Shared definitions for the PMOD LED arbiter.
//   - arb_state_e : FSM state encodings (ST_IDLE / ST_OWN / ST_SWITCH, 2 bits)
//   - LED_W       : width of one LED pattern / the PMOD header
//   - rr_pick     : round-robin requester pick
// No ports; imported by pmod_led_arbiter.
package led_arb_pkg;

  localparam int unsigned LED_W   = 8;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN    = 2'd1,
    ST_SWITCH = 2'd2
  } arb_state_e;

  // First asserted request scanning last+1 .. last (mod num_req). The caller
  // qualifies the result with |req; with no request the return value is 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   last,
                                               input int unsigned        num_req);
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      cand;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      cand = 32'(last) + i;
      if (cand >= num_req) cand = cand - num_req;
      if (!found && (i <= num_req) && req[cand[IDX_W-1:0]]) begin
        pick  = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler for the LED arbiter.
// Ports:
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   tick   : registered one-cycle pulse, high while the count is all-ones,
//            i.e. once every 2**PRESCALE_W cycles
module led_tick_gen #(
  parameter int unsigned PRESCALE_W = 20
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  // Registering the compare one count early keeps tick aligned with the
  // cycle in which the counter itself reads all-ones.
  localparam logic [PRESCALE_W-1:0] PreWrap = ~(PRESCALE_W'(1));

  logic [PRESCALE_W-1:0] cnt_q;
  logic                  tick_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + PRESCALE_W'(1);
      tick_q <= (cnt_q == PreWrap);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pmod_led_arbiter.sv
// Shares the 8-bit PMOD LED header among NUM_REQ requesters with a
// round-robin grant and a minimum dwell (in prescaler ticks) per owner.
// With nobody requesting, the header shows a free-running idle counter.
// Ports:
//   clk      : system clock
//   resetn   : asynchronous active-low reset
//   req      : per-requester level request
//   led_data : requester i pattern in bits [8i+7:8i]
//   gnt      : registered one-hot grant
//   busy     : high while the FSM is in ST_OWN or ST_SWITCH
//   pmod_a   : registered LED pins
// Build option: define LED_ARB_PREEMPT_EN to give req[0] priority; it then
// preempts any other owner regardless of dwell and wins every new pick.
module pmod_led_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned PRESCALE_W = 20,
  parameter int unsigned DWELL      = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] led_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic [LED_W-1:0]         pmod_a
);

  localparam int unsigned DwellW = $clog2(DWELL + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [LED_W-1:0]   pmod_q, pmod_d;
  logic [LED_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [DwellW-1:0]  dwell_q, dwell_d;

  logic               tick;
  logic [MAX_REQ-1:0] req_ext;
  logic [LED_W-1:0]   led_arr [NUM_REQ];
  logic [LED_W-1:0]   owner_data;
  logic               owner_req;
  logic               other_req;
  logic               any_req;
  logic               preempt;
  logic [IDX_W-1:0]   pick;
  logic [NUM_REQ-1:0] pick_onehot;

  led_tick_gen #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tick_gen (
    .clk   (clk),
    .resetn(resetn),
    .tick  (tick)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign led_arr[g] = led_data[g*LED_W +: LED_W];
  end

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
  end

  assign any_req = |req;

  // Current owner's pattern and request, plus whether anyone else is waiting.
  always_comb begin
    owner_data = '0;
    owner_req  = 1'b0;
    other_req  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_data = led_arr[i];
        owner_req  = req[i];
      end else if (req[i]) begin
        other_req = 1'b1;
      end
    end
  end

`ifdef LED_ARB_PREEMPT_EN
  assign pick    = req[0] ? '0 : rr_pick(req_ext, last_q, NUM_REQ);
  assign preempt = req[0] && (owner_q != '0);
`else
  assign pick    = rr_pick(req_ext, last_q, NUM_REQ);
  assign preempt = 1'b0;
`endif

  always_comb begin
    pick_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_onehot[i] = (pick == IDX_W'(i));
    end
  end

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (tick) idle_cnt_d = idle_cnt_q + LED_W'(1);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    pmod_d  = pmod_q;
    owner_d = owner_q;
    last_d  = last_q;
    dwell_d = dwell_q;

    case (state_q)
      ST_IDLE: begin
        pmod_d = idle_cnt_q;
        if (any_req) begin
          state_d = ST_OWN;
          gnt_d   = pick_onehot;
          owner_d = pick;
          last_d  = pick;
          dwell_d = DwellW'(DWELL);
        end
      end

      ST_OWN: begin
        pmod_d = owner_data;
        if (tick && (dwell_q != '0)) dwell_d = dwell_q - DwellW'(1);
        // Exit decisions use the registered dwell, so the cycle in which a
        // tick takes dwell to zero still holds the grant.
        if (!owner_req || ((dwell_q == '0) && other_req) || preempt) begin
          state_d = ST_SWITCH;
          gnt_d   = '0;
        end
      end

      ST_SWITCH: begin
        if (any_req) begin
          state_d = ST_OWN;
          gnt_d   = pick_onehot;
          owner_d = pick;
          last_d  = pick;
          dwell_d = DwellW'(DWELL);
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      pmod_q     <= '0;
      idle_cnt_q <= '0;
      owner_q    <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      dwell_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      pmod_q     <= pmod_d;
      idle_cnt_q <= idle_cnt_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      dwell_q    <= dwell_d;
    end
  end

  assign gnt    = gnt_q;
  assign pmod_a = pmod_q;
  assign busy   = (state_q == ST_OWN) || (state_q == ST_SWITCH);

endmodule

// File: tb/tb_pmod_led_arbiter.sv
// Self-checking bench for pmod_led_arbiter (NUM_REQ=4, PRESCALE_W=4, DWELL=2).
// A behavioural model tracks the owner, the one-cycle hand-over gap, the
// dwell budget and the idle counter from edge counts since reset release.
module tb_pmod_led_arbiter;

  localparam int NR    = 4;
  localparam int PW    = 4;
  localparam int DW    = 2;
  localparam int TICKP = 16;
`ifdef LED_ARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req;
  logic [31:0] led_data;
  logic [3:0]  gnt;
  logic        busy;
  logic [7:0]  pmod_a;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_k, m_idle, m_pmod, m_owner, m_gap, m_last, m_dwell;

  always #5 clk = ~clk;

  pmod_led_arbiter #(
    .NUM_REQ   (NR),
    .PRESCALE_W(PW),
    .DWELL     (DW)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .led_data(led_data),
    .gnt     (gnt),
    .busy    (busy),
    .pmod_a  (pmod_a)
  );

  function automatic int m_pick(input logic [3:0] r);
    int c;
    if (PREEMPT && r[0]) return 0;
    for (int i = 1; i <= NR; i++) begin
      c = (m_last + i) % NR;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_gnt();
    return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  function automatic logic m_busy();
    return (m_owner >= 0) || (m_gap != 0);
  endfunction

  task automatic model_reset();
    m_k = 0; m_idle = 0; m_pmod = 0; m_owner = -1; m_gap = 0; m_last = NR - 1; m_dwell = 0;
  endtask

  // One clock edge worth of behaviour, from the inputs present at the edge.
  task automatic model_step(input logic [3:0] r, input logic [31:0] d);
    bit tick;
    bit leave;
    int p;
    tick = (m_k % TICKP) == (TICKP - 1);
    if (m_owner >= 0) begin
      m_pmod = int'((d >> (8 * m_owner)) & 32'hFF);
      leave  = !r[m_owner] || (m_dwell == 0 && (r & ~(4'b0001 << m_owner)) != 4'b0000);
      if (PREEMPT && m_owner != 0 && r[0]) leave = 1'b1;
      if (tick && m_dwell > 0) m_dwell--;
      if (leave) begin
        m_owner = -1;
        m_gap   = 1;
      end
    end else begin
      if (m_gap == 0) m_pmod = m_idle;
      m_gap = 0;
      p = m_pick(r);
      if (p >= 0) begin
        m_owner = p; m_last = p; m_dwell = DW;
      end
    end
    if (tick) m_idle = (m_idle + 1) % 256;
    m_k++;
  endtask

  task automatic step();
    @(posedge clk);
    model_step(req, led_data);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    req    = 4'b0000;
    #2;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    req      = 4'b0000;
    led_data = 32'h0;
    #12;
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (pmod_a !== 8'h00) begin n_fail++; $display("FAIL reset_pmod: got %h want 00", pmod_a); end
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_idle_count();
    logic [7:0] prev;
    int last_chg;
    int changes;
    prev = pmod_a; last_chg = -1; changes = 0;
    for (int k = 1; k <= 64; k++) begin
      step();
      n_tests++; if (pmod_a !== 8'(m_pmod)) begin n_fail++; $display("FAIL idle_pmod k=%0d: got %h want %h", k, pmod_a, 8'(m_pmod)); end
      n_tests++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_gnt k=%0d: got gnt=%b busy=%b want 0000/0", k, gnt, busy); end
      if (pmod_a !== prev) begin
        changes++;
        if (last_chg >= 0) begin
          n_tests++; if (k - last_chg != TICKP) begin n_fail++; $display("FAIL idle_interval: got %0d want %0d", k - last_chg, TICKP); end
        end
        last_chg = k;
        prev = pmod_a;
      end
    end
    n_tests++; if (pmod_a !== 8'd3) begin n_fail++; $display("FAIL idle_final: got %0d want 3", pmod_a); end
    n_tests++; if (changes != 3) begin n_fail++; $display("FAIL idle_steps: got %0d want 3", changes); end
  endtask

  task automatic test_single_owner();
    apply_reset();
    led_data = {$urandom} & 32'hFFFFFF00 | 32'h000000A5;
    req = 4'b0001;
    step();
    n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL own_gnt: got %b want 0001", gnt); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL own_busy: got %b want 1", busy); end
    step();
    n_tests++; if (pmod_a !== 8'hA5) begin n_fail++; $display("FAIL own_pmod: got %h want a5", pmod_a); end
    for (int k = 0; k < 100; k++) begin
      step();
      n_tests++; if (gnt !== 4'b0001 || gnt !== m_gnt()) begin n_fail++; $display("FAIL own_hold k=%0d: got %b want 0001", k, gnt); end
    end
  endtask

  task automatic test_dwell_switch();
    logic [3:0] want;
    apply_reset();
    led_data = 32'h5A3C_7EA5;
    req = 4'b0001;
    step();
    req = 4'b0101;
    for (int k = 2; k <= 40; k++) begin
      step();
      want = (k <= 32) ? 4'b0001 : (k == 33) ? 4'b0000 : 4'b0100;
      n_tests++; if (gnt !== want || gnt !== m_gnt()) begin n_fail++; $display("FAIL dwell_gnt k=%0d: got %b want %b", k, gnt, want); end
      if (k == 33) begin
        n_tests++; if (pmod_a !== 8'hA5 || busy !== 1'b1) begin n_fail++; $display("FAIL dwell_gap: got pmod=%h busy=%b want a5/1", pmod_a, busy); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] cur;
    int zero_run, nxt, grants, idx;
    apply_reset();
    led_data = $urandom;
    req = 4'b1111;
    cur = 4'b0000; zero_run = 0; nxt = 0; grants = 0;
    for (int k = 1; k <= 20 * TICKP; k++) begin
      step();
      n_tests++; if (gnt !== m_gnt() || pmod_a !== 8'(m_pmod)) begin n_fail++; $display("FAIL rr_model k=%0d: got %b/%h want %b/%h", k, gnt, pmod_a, m_gnt(), 8'(m_pmod)); end
      if (gnt === 4'b0000) begin
        zero_run++;
      end else if (gnt !== cur) begin
        idx = -1;
        for (int i = 0; i < NR; i++) if (gnt === (4'b0001 << i)) idx = i;
        n_tests++; if (idx != nxt) begin n_fail++; $display("FAIL rr_order: got gnt=%b want index %0d", gnt, nxt); end
        if (grants > 0) begin
          n_tests++; if (zero_run != 1) begin n_fail++; $display("FAIL rr_gap: got %0d idle clk want 1", zero_run); end
        end
        nxt = (nxt + 1) % NR;
        grants++;
        zero_run = 0;
        cur = gnt;
      end
    end
    n_tests++; if (grants < 8) begin n_fail++; $display("FAIL rr_count: got %0d grants want >=8", grants); end
  endtask

  task automatic test_drop_to_idle();
    apply_reset();
    led_data = 32'h0000_3C00;
    req = 4'b0010;
    for (int k = 0; k < 5; k++) step();
    n_tests++; if (gnt !== 4'b0010 || pmod_a !== 8'h3C) begin n_fail++; $display("FAIL drop_pre: got %b/%h want 0010/3c", gnt, pmod_a); end
    req = 4'b0000;
    step();
    n_tests++; if (gnt !== 4'b0000 || busy !== 1'b1 || pmod_a !== 8'h3C) begin n_fail++; $display("FAIL drop_switch: got %b/%b/%h want 0000/1/3c", gnt, busy, pmod_a); end
    step();
    n_tests++; if (busy !== 1'b0 || gnt !== 4'b0000) begin n_fail++; $display("FAIL drop_idle: got busy=%b gnt=%b want 0/0000", busy, gnt); end
    for (int k = 0; k < 30; k++) begin
      step();
      n_tests++; if (pmod_a !== 8'(m_pmod) || pmod_a !== 8'((m_k - 1) / TICKP)) begin n_fail++; $display("FAIL drop_pmod k=%0d: got %h want %h", k, pmod_a, 8'((m_k - 1) / TICKP)); end
    end
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    led_data = 32'h0000_00A5;
    req = 4'b0001;
    for (int k = 0; k < 3; k++) step();
    n_tests++; if (gnt !== 4'b0001 || pmod_a !== 8'hA5) begin n_fail++; $display("FAIL rst_pre: got %b/%h want 0001/a5", gnt, pmod_a); end
    #2;
    resetn = 1'b0;
    #1;
    n_tests++; if (gnt !== 4'b0000 || pmod_a !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got %b/%h/%b want 0000/00/0", gnt, pmod_a, busy); end
    @(negedge clk);
    resetn = 1'b1;
    req = 4'b0000;
    model_reset();
  endtask

  task automatic test_preempt();
    int first;
    int want;
    apply_reset();
    led_data = $urandom;
    req = 4'b1000;
    step();
    n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL pre_own: got %b want 1000", gnt); end
    step();
    req = 4'b1001;
    first = -1;
    want = PREEMPT ? 4 : 34;
    for (int k = 3; k <= 40; k++) begin
      step();
      n_tests++; if (gnt !== m_gnt()) begin n_fail++; $display("FAIL pre_model k=%0d: got %b want %b", k, gnt, m_gnt()); end
      if (first < 0 && gnt === 4'b0001) first = k;
    end
    n_tests++; if (first != want) begin n_fail++; $display("FAIL pre_edge: got %0d want %0d", first, want); end
  endtask

  task automatic test_random();
    apply_reset();
    led_data = $urandom;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      if ($urandom_range(0, 15) == 0) led_data = $urandom;
      step();
      n_tests++; if (gnt !== m_gnt()) begin n_fail++; $display("FAIL rand_gnt k=%0d: got %b want %b", k, gnt, m_gnt()); end
      n_tests++; if (busy !== m_busy()) begin n_fail++; $display("FAIL rand_busy k=%0d: got %b want %b", k, busy, m_busy()); end
      n_tests++; if (pmod_a !== 8'(m_pmod)) begin n_fail++; $display("FAIL rand_pmod k=%0d: got %h want %h", k, pmod_a, 8'(m_pmod)); end
      n_tests++; if ($countones(gnt) > 1) begin n_fail++; $display("FAIL rand_onehot k=%0d: got %b want <=1 bit", k, gnt); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_count();
    test_single_owner();
    test_dwell_switch();
    test_round_robin();
    test_drop_to_idle();
    test_reset_mid_grant();
    test_preempt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
